// File: rtl/ucsbece154b_fifo_param.sv
// Parametrised synchronous FIFO: depth/width params, occupancy count, almost flags, flush, error pulses.
// Latency: status one cycle after request; data_o show-ahead with UCSBECE154B_FIFO_FWFT_EN, else registered on pop.
// Backpressure: push on full accepted only alongside an accepted pop; rejected requests pulse overflow_o/underflow_o.
module ucsbece154b_fifo_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int NR_ENTRIES    = 8,
    parameter int AFULL_THRESH  = NR_ENTRIES - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               push_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic                               pop_i,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
    output logic                               full_o,
    output logic                               almost_full_o,
    output logic                               almost_empty_o,
    output logic [$clog2(NR_ENTRIES+1)-1:0]    count_o,
    output logic                               overflow_o,
    output logic                               underflow_o
);
    localparam int CW = $clog2(NR_ENTRIES + 1);
    localparam int PW = $clog2(NR_ENTRIES);

    logic [DATA_WIDTH-1:0] mem [NR_ENTRIES];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count;
    logic [31:0]           count_ext;
    logic                  pop_acc, push_acc;
    logic                  ovf_q, unf_q;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NR_ENTRIES - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_acc  = pop_i & ~flush_i & (count != '0);
    assign push_acc = push_i & ~flush_i & ((count < CW'(NR_ENTRIES)) | pop_acc);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_acc) tail <= ptr_inc(tail);
            if (pop_acc)  head <= ptr_inc(head);
            count <= count + CW'(push_acc) - CW'(pop_acc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_acc) mem[tail] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= push_i & ~flush_i & ~push_acc;
            unf_q <= pop_i & ~flush_i & ~pop_acc;
        end
    end

`ifdef UCSBECE154B_FIFO_FWFT_EN
    assign data_o = mem[head];
`else
    logic [DATA_WIDTH-1:0] data_q;

    // Holds the last popped word; flush deliberately leaves it alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)      data_q <= '0;
        else if (pop_acc) data_q <= mem[head];
    end
    assign data_o = data_q;
`endif

    assign count_ext      = 32'(count);
    assign count_o        = count;
    assign valid_o        = (count != '0);
    assign full_o         = (count == CW'(NR_ENTRIES));
    assign almost_full_o  = (count_ext >= AFULL_THRESH);
    assign almost_empty_o = (count_ext <= AEMPTY_THRESH);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
endmodule

// File: tb/tb_ucsbece154b_fifo_param.sv
// Bench for ucsbece154b_fifo_param: depth-8 instance for main behaviour, depth-5 instance for pointer wrap.
module tb_ucsbece154b_fifo_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_a = 1'b0, push_a = 1'b0, pop_a = 1'b0;
    logic [31:0] data_a = '0;
    logic [31:0] dout_a;
    logic        valid_a, full_a, afull_a, aempty_a, ovf_a, unf_a;
    logic [3:0]  count_a;

    logic        flush_b = 1'b0, push_b = 1'b0, pop_b = 1'b0;
    logic [31:0] data_b = '0;
    logic [31:0] dout_b;
    logic        valid_b, full_b, afull_b, aempty_b, ovf_b, unf_b;
    logic [2:0]  count_b;

    int checks = 0;
    int passed = 0;

    logic [31:0] mq[$];
    logic [31:0] qb[$];
`ifndef UCSBECE154B_FIFO_FWFT_EN
    logic [31:0] exp_dreg, exp_dreg_b;
`endif
    logic exp_ovf, exp_unf;

    always #5 clk = ~clk;

    ucsbece154b_fifo_param #(.DATA_WIDTH(32), .NR_ENTRIES(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a), .push_i(push_a),
        .data_i(data_a), .pop_i(pop_a), .data_o(dout_a), .valid_o(valid_a),
        .full_o(full_a), .almost_full_o(afull_a), .almost_empty_o(aempty_a),
        .count_o(count_a), .overflow_o(ovf_a), .underflow_o(unf_a)
    );

    ucsbece154b_fifo_param #(.DATA_WIDTH(32), .NR_ENTRIES(5)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b), .push_i(push_b),
        .data_i(data_b), .pop_i(pop_b), .data_o(dout_b), .valid_o(valid_b),
        .full_o(full_b), .almost_full_o(afull_b), .almost_empty_o(aempty_b),
        .count_o(count_b), .overflow_o(ovf_b), .underflow_o(unf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_a(input string tag);
        int n;
        n = mq.size();
        check({tag, "/count"},  32'(count_a),  32'(n));
        check({tag, "/valid"},  32'(valid_a),  32'(n != 0));
        check({tag, "/full"},   32'(full_a),   32'(n == 8));
        check({tag, "/afull"},  32'(afull_a),  32'(n >= 7));
        check({tag, "/aempty"}, 32'(aempty_a), 32'(n <= 1));
        check({tag, "/ovf"},    32'(ovf_a),    32'(exp_ovf));
        check({tag, "/unf"},    32'(unf_a),    32'(exp_unf));
`ifdef UCSBECE154B_FIFO_FWFT_EN
        if (n != 0) check({tag, "/head"}, dout_a, mq[0]);
`else
        check({tag, "/dreg"}, dout_a, exp_dreg);
`endif
    endtask

    task automatic cyc_a(input logic pu, input logic po, input logic [31:0] d,
                         input logic fl, input string tag);
        logic pop_ok, push_ok;
        push_a = pu; pop_a = po; data_a = d; flush_a = fl;
        pop_ok  = po & ~fl & (mq.size() != 0);
        push_ok = pu & ~fl & ((mq.size() < 8) | pop_ok);
`ifdef UCSBECE154B_FIFO_FWFT_EN
        if (pop_ok) check({tag, "/popdata"}, dout_a, mq[0]);
`endif
        @(posedge clk); #1;
        if (pop_ok) begin
`ifdef UCSBECE154B_FIFO_FWFT_EN
            void'(mq.pop_front());
`else
            exp_dreg = mq.pop_front();
`endif
        end
        if (push_ok) mq.push_back(d);
        if (fl) mq.delete();
        exp_ovf = pu & ~fl & ~push_ok;
        exp_unf = po & ~fl & ~pop_ok;
        push_a = 1'b0; pop_a = 1'b0; flush_a = 1'b0;
        check_a(tag);
    endtask

    task automatic cyc_b(input logic pu, input logic po, input logic [31:0] d, input string tag);
        logic pop_ok, push_ok;
        push_b = pu; pop_b = po; data_b = d;
        pop_ok  = po & (qb.size() != 0);
        push_ok = pu & ((qb.size() < 5) | pop_ok);
`ifdef UCSBECE154B_FIFO_FWFT_EN
        if (pop_ok) check({tag, "/popdata"}, dout_b, qb[0]);
`endif
        @(posedge clk); #1;
        if (pop_ok) begin
`ifdef UCSBECE154B_FIFO_FWFT_EN
            void'(qb.pop_front());
`else
            exp_dreg_b = qb.pop_front();
            check({tag, "/dreg"}, dout_b, exp_dreg_b);
`endif
        end
        if (push_ok) qb.push_back(d);
        push_b = 1'b0; pop_b = 1'b0;
        check({tag, "/count"}, 32'(count_b), 32'(qb.size()));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; push_a = 1'b1; pop_a = 1'b1; data_a = 32'hDEAD;
        @(posedge clk); #1;
        rst_n = 1'b1; push_a = 1'b0; pop_a = 1'b0;
        mq.delete(); qb.delete();
`ifndef UCSBECE154B_FIFO_FWFT_EN
        exp_dreg = '0; exp_dreg_b = '0;
`endif
        exp_ovf = 1'b0; exp_unf = 1'b0;
        check_a(tag);
        check({tag, "/b_count"}, 32'(count_b), 32'd0);
        check({tag, "/b_aempty"}, 32'(aempty_b), 32'd1);
    endtask

    initial begin
        do_reset("reset");

        for (int i = 0; i < 8; i++) cyc_a(1'b1, 1'b0, 32'h11 + i, 1'b0, "fill");
        cyc_a(1'b1, 1'b0, 32'h99, 1'b0, "push_full");
        cyc_a(1'b0, 1'b0, '0, 1'b0, "idle_after_ovf");

        cyc_a(1'b1, 1'b1, 32'hAA, 1'b0, "full_pushpop");
        for (int i = 0; i < 8; i++) cyc_a(1'b0, 1'b1, '0, 1'b0, "drain");
        cyc_a(1'b0, 1'b1, '0, 1'b0, "pop_empty");
        cyc_a(1'b0, 1'b0, '0, 1'b0, "idle_after_unf");

        cyc_a(1'b1, 1'b1, 32'h55, 1'b0, "empty_pushpop");
        cyc_a(1'b0, 1'b0, '0, 1'b0, "show_55");
        cyc_a(1'b0, 1'b1, '0, 1'b0, "pop_55");

        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 32'h60 + i, 1'b0, "prefill");
        cyc_a(1'b1, 1'b1, 32'h77, 1'b1, "flush");
        cyc_a(1'b0, 1'b0, '0, 1'b0, "after_flush");

        for (int i = 0; i < 3; i++) cyc_a(1'b1, 1'b0, 32'h70 + i, 1'b0, "pre_rst");
        cyc_a(1'b0, 1'b1, '0, 1'b0, "pre_rst_pop");
        do_reset("mid_reset");

        for (int i = 0; i < 3; i++) cyc_b(1'b1, 1'b0, 32'hB0 + i, "b_fill");
        for (int i = 0; i < 12; i++) cyc_b(1'b1, 1'b1, 32'hC0 + i, "b_wrap");
        for (int i = 0; i < 3; i++) cyc_b(1'b0, 1'b1, '0, "b_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ucsbece154b_fifo_param.md
# ucsbece154b_fifo_param

Parametrised synchronous FIFO, successor to the team's 4-entry queue, for buffering between pipeline stages (fetch/decode queues, store buffers). Adds arbitrary depth, an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and overflow/underflow error pulses. Read mode is compile-time selectable: first-word-fall-through or registered pop data.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1)
- NR_ENTRIES, 8, depth in entries (≥2; need not be a power of two)
- AFULL_THRESH, NR_ENTRIES-1, almost_full_o asserted when count ≥ this value
- AEMPTY_THRESH, 1, almost_empty_o asserted when count ≤ this value

Ports (CW = $clog2(NR_ENTRIES+1)):
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  synchronous discard of all contents
- push_i  in  1  write request
- data_i  in  DATA_WIDTH  write data
- pop_i  in  1  read request
- data_o  out  DATA_WIDTH  read data (mode-dependent, see Configuration)
- valid_o  out  1  FIFO non-empty (count ≠ 0)
- full_o  out  1  count == NR_ENTRIES
- almost_full_o  out  1  count ≥ AFULL_THRESH
- almost_empty_o  out  1  count ≤ AEMPTY_THRESH
- count_o  out  CW  current occupancy, 0..NR_ENTRIES
- overflow_o  out  1  one-cycle pulse: push_i rejected last cycle
- underflow_o  out  1  one-cycle pulse: pop_i rejected last cycle

## Operation
- State: storage array, head/tail pointers ($clog2(NR_ENTRIES) bits), count register (CW bits).
- pop_acc = pop_i & ~flush_i & (count ≠ 0). No bypass: pop on empty is rejected even with simultaneous push.
- push_acc = push_i & ~flush_i & (count < NR_ENTRIES | pop_acc). Push on full accepted only if a pop is accepted in the same cycle.
- Accepted push: mem[tail] ← data_i; tail advances. Accepted pop: head advances.
- Pointer wrap: at NR_ENTRIES-1 the next value is 0 (explicit compare, not power-of-two rollover).
- count_next = count + push_acc − pop_acc; push+pop together leaves count unchanged.
- Flush: head, tail, count ← 0; overrides push_i/pop_i that cycle; no error pulses; storage contents not cleared.
- overflow_o ← push_i & ~flush_i & ~push_acc; underflow_o ← pop_i & ~flush_i & ~pop_acc (registered).
- valid_o, full_o, almost_*_o, count_o are decoded from the count register only (no input paths).

## Timing
- Reset (rst_ni low at clock edge): head, tail, count ← 0; valid_o=0, full_o=0, almost_full_o=(AFULL_THRESH==0), almost_empty_o=1, count_o=0, overflow_o=0, underflow_o=0, data_o=0 (registered mode). Reset mid-operation discards all entries; reset has priority over flush.
- Push at edge N → valid_o/count_o reflect it after edge N (visible in cycle N+1).
- Status flags and count change only on clock edges; one-cycle latency from request to status.
- Error pulses are high exactly one cycle, in the cycle after the rejected request.
- Full with push+pop: entry written at tail (== head) while old head is read; count stays NR_ENTRIES, full_o stays 1.

## Configuration
- Macro UCSBECE154B_FIFO_FWFT_EN.
- Defined: data_o = mem[head] combinationally; valid whenever valid_o=1; pop_i consumes the shown word. Data written to an empty FIFO appears on data_o the cycle after the push (no write-through).
- Undefined: data_o is a register loaded with mem[head] on an accepted pop; word available the cycle after the pop and held until the next accepted pop or reset; flush does not change data_o.

## Test plan
- Reset then push 0x11..0x18 one per cycle (NR_ENTRIES=8) → count_o 1..8, full_o=1 after 8th, almost_full_o=1 from count 7; 9th push → overflow_o pulse, count stays 8.
- Pop 8 times from full → data 0x11..0x18 in order (FWFT: same cycle; registered: next cycle); valid_o=0 after last, almost_empty_o=1 at count ≤1; extra pop → underflow_o pulse.
- Full FIFO, push 0xAA + pop same cycle → pops 0x11, count stays 8, 0xAA read last after 0x12..0x18.
- Empty FIFO, push 0x55 + pop same cycle → pop rejected, underflow_o pulse, count_o=1, data_o shows 0x55 next cycle (FWFT).
- NR_ENTRIES=5: 12 push/pop pairs at count 3 → pointers wrap 4→0, data order preserved, count_o constant 3.
- count 4, flush_i with push_i=pop_i=1 → count_o=0, valid_o=0, no error pulses; rst_ni low mid-stream → all outputs at reset values next cycle.
